// File: rtl/spi_reg_bridge_if.sv
// Byte-stream and register-bank signals between SPI_SLAVE-side logic and spi_reg_bridge.
interface spi_reg_bridge_if #(
   parameter int unsigned REG_COUNT = 8
) ();
   logic                   cs_n;
   logic [7:0]             rx_data;
   logic                   rx_vld;
   logic [7:0]             tx_data;
   logic                   tx_vld;
   logic                   tx_ready;
   logic [REG_COUNT*8-1:0] reg_out;
   logic                   err;
   logic                   frame_done;

   modport slave (
      input  cs_n, rx_data, rx_vld, tx_ready,
      output tx_data, tx_vld, reg_out, err, frame_done
   );

   modport master (
      output cs_n, rx_data, rx_vld, tx_ready,
      input  tx_data, tx_vld, reg_out, err, frame_done
   );
endinterface

// File: rtl/spi_reg_bridge.sv
// Decodes CS-framed command/address/data bytes from SPI_SLAVE into a register bank
// with auto-increment burst read and write.
module spi_reg_bridge #(
   parameter int unsigned REG_COUNT = 8,
   parameter logic [7:0]  RESET_VAL = 8'hFF,
   parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
   input logic             i_clk,
   input logic             i_rst,
   spi_reg_bridge_if.slave bus
);
   localparam int unsigned AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CMD     = 3'd1;
   localparam logic [2:0] ST_WRITE   = 3'd2;
   localparam logic [2:0] ST_READ    = 3'd3;
   localparam logic [2:0] ST_DISCARD = 3'd4;

   logic                   r_cs_meta;
   logic                   r_cs_s;
   logic                   r_cs_d;
   logic [2:0]             r_fill;
   logic [2:0]             r_state;
   logic [AW-1:0]          r_addr;
   logic [7:0]             r_regs [REG_COUNT];
   logic [7:0]             r_tx_data;
   logic                   r_tx_vld;
   logic                   r_err;
   logic                   r_frame_done;

   logic                   w_cs_fall;
   logic                   w_cmd_bad;
   logic [AW-1:0]          w_addr_next;
   logic [REG_COUNT*8-1:0] w_reg_out;

   // r_fill marks when r_cs_d holds a real pin sample; without it the reset value 1
   // would fake a falling edge when CS_N is still low after RST, starting a stale frame.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cs_meta <= 1'b1;
         r_cs_s    <= 1'b1;
         r_cs_d    <= 1'b1;
         r_fill    <= '0;
      end else begin
         r_cs_meta <= bus.cs_n;
         r_cs_s    <= r_cs_meta;
         r_cs_d    <= r_cs_s;
         r_fill    <= {r_fill[1:0], 1'b1};
      end
   end

   assign w_cs_fall   = r_fill[2] & r_cs_d & ~r_cs_s;
   assign w_cmd_bad   = {1'b0, bus.rx_data[6:0]} >= 8'(REG_COUNT);
   assign w_addr_next = (r_addr == AW'(REG_COUNT - 1)) ? '0 : r_addr + AW'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_tx_data    <= IDLE_BYTE;
         r_tx_vld     <= 1'b0;
         r_err        <= 1'b0;
         r_frame_done <= 1'b0;
         for (int unsigned i = 0; i < REG_COUNT; i++) r_regs[i] <= RESET_VAL;
      end else begin
         r_err        <= 1'b0;
         r_frame_done <= 1'b0;
         if (r_state == ST_IDLE) begin
            r_tx_data <= IDLE_BYTE;
            r_tx_vld  <= 1'b1;
            if (w_cs_fall) r_state <= ST_CMD;
         end else if (r_cs_s) begin
            // Frame end wins over a coincident RX strobe.
            r_state      <= ST_IDLE;
            r_tx_data    <= IDLE_BYTE;
            r_tx_vld     <= 1'b1;
            r_frame_done <= (r_state != ST_CMD);
         end else begin
            case (r_state)
               ST_CMD: begin
                  r_tx_data <= IDLE_BYTE;
                  r_tx_vld  <= 1'b1;
                  if (bus.rx_vld) begin
                     if (w_cmd_bad) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DISCARD;
                     end else begin
                        r_addr <= bus.rx_data[AW-1:0];
                        if (bus.rx_data[7]) begin
                           r_state   <= ST_READ;
                           r_tx_data <= r_regs[bus.rx_data[AW-1:0]];
                        end else begin
                           r_state <= ST_WRITE;
                        end
                     end
                  end
               end
               ST_WRITE: begin
                  r_tx_data <= IDLE_BYTE;
                  r_tx_vld  <= 1'b1;
                  if (bus.rx_vld) begin
                     r_regs[r_addr] <= bus.rx_data;
                     r_addr         <= w_addr_next;
                  end
               end
               ST_READ: begin
                  if (r_tx_vld && bus.tx_ready) begin
                     r_tx_vld <= 1'b0;
                     r_addr   <= w_addr_next;
                  end else if (!r_tx_vld) begin
                     r_tx_data <= r_regs[r_addr];
                     r_tx_vld  <= 1'b1;
                  end
               end
               ST_DISCARD: begin
                  r_tx_data <= IDLE_BYTE;
                  r_tx_vld  <= 1'b1;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      w_reg_out = '0;
      for (int unsigned i = 0; i < REG_COUNT; i++) w_reg_out[8*i +: 8] = r_regs[i];
   end

   assign bus.reg_out    = w_reg_out;
   assign bus.tx_data    = r_tx_data;
   assign bus.tx_vld     = r_tx_vld;
   assign bus.err        = r_err;
   assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed plus randomized frames for spi_reg_bridge (REG_COUNT=4) against an array-based model.
module tb_spi_reg_bridge;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   fd_cnt = 0;
   int   err_cnt = 0;
   logic [7:0] m_regs [4];

   spi_reg_bridge_if #(.REG_COUNT(4)) bus ();

   spi_reg_bridge #(
      .REG_COUNT(4),
      .RESET_VAL(8'hFF),
      .IDLE_BYTE(8'h00)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (bus.err === 1'b1) err_cnt++;
   end

   function automatic logic [31:0] model_out();
      return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_data = b;
      bus.rx_vld  = 1'b1;
      tick();
      bus.rx_vld  = 1'b0;
   endtask

   task automatic frame_start();
      bus.cs_n = 1'b0;
      repeat (4) tick();
   endtask

   task automatic frame_end(input string tag, input int exp_fd);
      int fd0;
      fd0 = fd_cnt;
      bus.cs_n = 1'b1;
      repeat (4) tick();
      chk({tag, "_frame_done"}, 32'(fd_cnt - fd0), 32'(exp_fd));
      chk({tag, "_tx_idle"}, {23'd0, bus.tx_vld, bus.tx_data}, 32'h100);
   endtask

   task automatic handshake(input string tag, input logic [7:0] exp_data);
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      chk({tag, "_vld_gap"}, 32'(bus.tx_vld), 32'd0);
      tick();
      chk({tag, "_next"}, {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b1, exp_data});
   endtask

   initial begin
      int e0;
      int a;
      logic [7:0] b;
      bus.cs_n = 1'b1; bus.rx_vld = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'hFF;

      // Reset
      repeat (2) tick();
      chk("rst_regs", bus.reg_out, model_out());
      chk("rst_tx", {23'd0, bus.tx_vld, bus.tx_data}, 32'h000);
      chk("rst_pulses", {30'd0, bus.err, bus.frame_done}, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_release_vld", 32'(bus.tx_vld), 32'd1);

      // Write burst to 1,2
      frame_start();
      send(8'h01); chk("wr_cmd", bus.reg_out, model_out());
      send(8'h12); m_regs[1] = 8'h12; chk("wr_r1", bus.reg_out, model_out());
      send(8'h34); m_regs[2] = 8'h34; chk("wr_r2", bus.reg_out, model_out());
      frame_end("wr", 1);

      // Read burst, then a READY held across the gap cycle advances only once
      frame_start();
      send(8'h81);
      chk("rd_first", {23'd0, bus.tx_vld, bus.tx_data}, 32'h112);
      handshake("rd1", 8'h34);
      bus.tx_ready = 1'b1;
      tick();
      chk("rd_gap2", 32'(bus.tx_vld), 32'd0);
      tick();
      bus.tx_ready = 1'b0;
      chk("rd_hold_ready", {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b1, m_regs[3]});
      chk("rd_no_side", bus.reg_out, model_out());
      frame_end("rd", 1);

      // Wrap from last register to 0
      frame_start();
      send(8'h03);
      send(8'hAA); m_regs[3] = 8'hAA; chk("wrap_r3", bus.reg_out, model_out());
      send(8'hBB); m_regs[0] = 8'hBB; chk("wrap_r0", bus.reg_out, model_out());
      frame_end("wrap", 1);

      // Bad address
      e0 = err_cnt;
      frame_start();
      send(8'h05);
      chk("bad_err_hi", 32'(bus.err), 32'd1);
      tick();
      chk("bad_err_lo", 32'(bus.err), 32'd0);
      send(8'h77);
      chk("bad_no_write", bus.reg_out, model_out());
      frame_end("bad", 1);
      chk("bad_err_count", 32'(err_cnt - e0), 32'd1);

      // Frame with no command byte ends without FRAME_DONE
      frame_start();
      frame_end("empty", 0);

      // Strobe coinciding with the synchronized CS rise is dropped
      frame_start();
      send(8'h00);
      send(8'h11); m_regs[0] = 8'h11;
      e0 = fd_cnt;
      bus.cs_n = 1'b1;
      repeat (2) tick();
      bus.rx_data = 8'h56; bus.rx_vld = 1'b1;
      tick();
      bus.rx_vld = 1'b0;
      chk("collide_drop", bus.reg_out, model_out());
      repeat (2) tick();
      chk("collide_fd", 32'(fd_cnt - e0), 32'd1);

      // Reset mid-write; CS_N still low afterwards must not open a frame
      frame_start();
      send(8'h02);
      send(8'h99); m_regs[2] = 8'h99; chk("pre_rst_wr", bus.reg_out, model_out());
      rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'hFF;
      chk("mid_rst_regs", bus.reg_out, model_out());
      chk("mid_rst_vld", 32'(bus.tx_vld), 32'd0);
      tick();
      rst = 1'b0;
      repeat (5) tick();
      send(8'h00);
      send(8'h44);
      chk("post_rst_no_frame", bus.reg_out, model_out());
      frame_end("post_rst", 0);

      // Idle noise
      e0 = err_cnt;
      for (int i = 0; i < 4; i++) begin
         send(8'($urandom));
         chk("idle_regs", bus.reg_out, model_out());
         chk("idle_tx", 32'(bus.tx_data), 32'd0);
      end
      chk("idle_err", 32'(err_cnt - e0), 32'd0);

      // Randomized frames
      for (int f = 0; f < 25; f++) begin
         int kind;
         int n;
         kind = int'($urandom_range(0, 2));
         n    = int'($urandom_range(0, 5));
         frame_start();
         if (kind == 2) begin
            send({1'($urandom), 7'($urandom_range(4, 127))});
            chk("rnd_bad_err", 32'(bus.err), 32'd1);
            for (int k = 0; k < n; k++) send(8'($urandom));
            chk("rnd_bad_regs", bus.reg_out, model_out());
         end else if (kind == 0) begin
            a = int'($urandom_range(0, 3));
            send(8'(a));
            for (int k = 0; k < n; k++) begin
               b = 8'($urandom);
               send(b);
               m_regs[a] = b;
               a = (a + 1) % 4;
               chk("rnd_wr", bus.reg_out, model_out());
            end
         end else begin
            a = int'($urandom_range(0, 3));
            send(8'h80 | 8'(a));
            chk("rnd_rd_first", {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b1, m_regs[a]});
            for (int k = 0; k < n; k++) begin
               if ($urandom_range(0, 1) == 1) send(8'($urandom));
               a = (a + 1) % 4;
               handshake("rnd_rd", m_regs[a]);
            end
            chk("rnd_rd_regs", bus.reg_out, model_out());
         end
         frame_end("rnd", 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
